turn_signal_ctrl: RTL and testbench
===================================

# turn_signal_ctrl

Command generator for the car lamp driver. It turns raw driver controls (power, turn-stalk requests, hazard button, brake) into the `stay` / `twinkle_left` / `twinkle_right` command triple that the lamp driver consumes. It enforces a minimum blink duration, self-cancels indicators, toggles hazard on a button edge, and applies a fixed priority among competing requests. It sits between the input-decoding logic and the lamp driver, on the same system clock.

## Interface
- `HOLD_CYCLES`, default 500: minimum indicator duration in clock cycles after the last sampled request; 500 cycles = 1 s at the 2 ms system clock; legal range ≥1.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `power_on`  in  1  car powered; 0 forces everything off.
- `turn_left_req`  in  1  left stalk level request.
- `turn_right_req`  in  1  right stalk level request.
- `hazard_btn`  in  1  hazard button level, already debounced; each rising edge toggles hazard.
- `brake`  in  1  brake pedal level.
- `stay`  out  1  to lamp driver: steady-on request.
- `twinkle_left`  out  1  to lamp driver: blink-left request.
- `twinkle_right`  out  1  to lamp driver: blink-right request.
- `hazard_on`  out  1  status: FSM is in HAZARD.

## Operation
- States: OFF, IDLE, LEFT, RIGHT, HAZARD. Hold counter `cnt` is 32 bits unsigned.
- Hazard edge: `hz_edge = hazard_btn & ~hz_prev`. `hz_prev` is a register that samples `hazard_btn` every cycle in every state, including OFF. Its reset value is 0.
- Priority, evaluated every edge: power off > hazard edge > turn requests > brake.
- Any state with `power_on`=0: go to OFF and set `cnt`=0. Edges are ignored while in OFF.
- OFF → IDLE when `power_on`=1.
- IDLE:
  - `hz_edge` → HAZARD.
  - Else left-only request (left=1, right=0) → LEFT with `cnt`=HOLD_CYCLES-1.
  - Else right-only request → RIGHT with `cnt`=HOLD_CYCLES-1.
  - Both requests high → remain in IDLE.
- LEFT:
  - `hz_edge` → HAZARD with `cnt`=0.
  - Else right-only request → RIGHT with `cnt`=HOLD_CYCLES-1 (direct swap, no IDLE gap).
  - Else `turn_left_req`=1 → reload `cnt`=HOLD_CYCLES-1.
  - Else `cnt`=0 → IDLE.
  - Else `cnt`←`cnt`-1.
  - Both requests high counts as "left held" (reload).
- RIGHT: mirror of LEFT.
- HAZARD:
  - `hz_edge` → IDLE.
  - Turn requests and brake are ignored.
- Output encoding, registered and driven from the next state:
  - OFF: `stay`/`twinkle_left`/`twinkle_right` = 000.
  - IDLE: `brake`,0,0.
  - LEFT: `brake`,1,0.
  - RIGHT: `brake`,0,1.
  - HAZARD: 1,1,1 (lamp driver shows both lamps steady).
- Encoding 011 is never produced.
- `hazard_on` = 1 exactly when the next state is HAZARD.

## Timing
- Reset (`rst_n`=0 at a posedge): state=OFF, `cnt`=0, `hz_prev`=0, and all outputs 0 from that edge. Reset mid-blink or mid-hazard drops outputs on the same edge.
- Latency: outputs reflect inputs sampled at edge k immediately after edge k (1 cycle). No combinational input-to-output path.
- Indicator duration: if the request is last sampled high at edge k, the twinkle output stays 1 through edge k+HOLD_CYCLES-1 and falls at edge k+HOLD_CYCLES. A 1-cycle request therefore gives exactly HOLD_CYCLES cycles of twinkle.
- HOLD_CYCLES=1: twinkle drops on the first edge the request is sampled low.
- Hazard held high toggles once only. Hazard pressed while OFF is absorbed by `hz_prev` and does not toggle at power-up.
- Hazard edge and power-off on the same edge: result is OFF.
- Hazard edge and turn request on the same edge: result is HAZARD.
- Hazard exit always lands in IDLE. A still-held turn request enters LEFT/RIGHT on the following edge.
- Brake changes `stay` 1 cycle later in IDLE/LEFT/RIGHT without affecting state or `cnt`.

## Test plan
- Reset/power: `rst_n`=0 for 2 cycles, then `power_on`=1 → outputs 000 during reset; IDLE 000 one cycle after power_on.
- One-shot left, HOLD_CYCLES=4: `turn_left_req` high for 1 cycle at edge k → `twinkle_left`=1 for exactly 4 cycles (edges k..k+3), 0 at k+4; `twinkle_right` stays 0.
- Swap: left held 10 cycles, then right-only → after the switch edge outputs go 010 → 001 with no 000 cycle; right counter reloaded to HOLD_CYCLES-1.
- Hazard: button held 20 cycles while left active → 111 and `hazard_on`=1 after the first edge; no re-toggle while held; release, press again → IDLE 000 (or 100 with brake=1).
- Brake overlay: in RIGHT, `brake` 0→1→0 → `stay` follows 1 cycle late (001→101→001); blink duration unchanged.
- Power/reset mid-operation: in HAZARD, `power_on`=0 coincident with a hazard edge → 000 next cycle, `hazard_on`=0. Re-power → IDLE, not HAZARD.

Source files
------------

// File: rtl/turn_signal_ctrl_if.sv
// Control-to-command bundle between the input decoder (master) and the
// turn signal command generator (slave).
interface turn_signal_ctrl_if;
    logic power_on;
    logic turn_left_req;
    logic turn_right_req;
    logic hazard_btn;
    logic brake;
    logic stay;
    logic twinkle_left;
    logic twinkle_right;
    logic hazard_on;

    modport master (
        output power_on, turn_left_req, turn_right_req, hazard_btn, brake,
        input  stay, twinkle_left, twinkle_right, hazard_on
    );

    modport slave (
        input  power_on, turn_left_req, turn_right_req, hazard_btn, brake,
        output stay, twinkle_left, twinkle_right, hazard_on
    );
endinterface

// File: rtl/turn_signal_ctrl.sv
// Turns driver controls into the stay/twinkle command triple for the lamp
// driver, with minimum blink hold, hazard toggle and fixed request priority.
module turn_signal_ctrl #(
    parameter int HOLD_CYCLES = 500
) (
    input logic              clk,
    input logic              rst_n,
    turn_signal_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_OFF,
        S_IDLE,
        S_LEFT,
        S_RIGHT,
        S_HAZARD
    } state_t;

    localparam logic [31:0] RELOAD = 32'(HOLD_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic        r_hz_prev;
    logic        r_stay;
    logic        r_tw_left;
    logic        r_tw_right;
    logic        r_hazard_on;

    state_t      w_next;
    logic [31:0] w_cnt_next;
    logic        w_hz_edge;
    logic        w_left_only;
    logic        w_right_only;
    logic        w_stay_next;
    logic        w_tl_next;
    logic        w_tr_next;

    assign w_hz_edge    = bus.hazard_btn & ~r_hz_prev;
    assign w_left_only  = bus.turn_left_req & ~bus.turn_right_req;
    assign w_right_only = bus.turn_right_req & ~bus.turn_left_req;

    // Priority: power off > hazard edge > turn requests > hold expiry.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        if (!bus.power_on) begin
            w_next     = S_OFF;
            w_cnt_next = 32'd0;
        end else begin
            case (r_state)
                S_OFF: w_next = S_IDLE;
                S_IDLE: begin
                    if (w_hz_edge) begin
                        w_next = S_HAZARD;
                    end else if (w_left_only) begin
                        w_next     = S_LEFT;
                        w_cnt_next = RELOAD;
                    end else if (w_right_only) begin
                        w_next     = S_RIGHT;
                        w_cnt_next = RELOAD;
                    end
                end
                S_LEFT: begin
                    if (w_hz_edge) begin
                        w_next     = S_HAZARD;
                        w_cnt_next = 32'd0;
                    end else if (w_right_only) begin
                        w_next     = S_RIGHT;
                        w_cnt_next = RELOAD;
                    end else if (bus.turn_left_req) begin
                        w_cnt_next = RELOAD;
                    end else if (r_cnt == 32'd0) begin
                        w_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt - 32'd1;
                    end
                end
                S_RIGHT: begin
                    if (w_hz_edge) begin
                        w_next     = S_HAZARD;
                        w_cnt_next = 32'd0;
                    end else if (w_left_only) begin
                        w_next     = S_LEFT;
                        w_cnt_next = RELOAD;
                    end else if (bus.turn_right_req) begin
                        w_cnt_next = RELOAD;
                    end else if (r_cnt == 32'd0) begin
                        w_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt - 32'd1;
                    end
                end
                S_HAZARD: begin
                    if (w_hz_edge) begin
                        w_next = S_IDLE;
                    end
                end
                default: begin
                    w_next     = S_OFF;
                    w_cnt_next = 32'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they land on the same edge.
    always_comb begin
        w_stay_next = 1'b0;
        w_tl_next   = 1'b0;
        w_tr_next   = 1'b0;
        case (w_next)
            S_IDLE:   w_stay_next = bus.brake;
            S_LEFT: begin
                w_stay_next = bus.brake;
                w_tl_next   = 1'b1;
            end
            S_RIGHT: begin
                w_stay_next = bus.brake;
                w_tr_next   = 1'b1;
            end
            S_HAZARD: begin
                w_stay_next = 1'b1;
                w_tl_next   = 1'b1;
                w_tr_next   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_OFF;
            r_cnt       <= 32'd0;
            r_hz_prev   <= 1'b0;
            r_stay      <= 1'b0;
            r_tw_left   <= 1'b0;
            r_tw_right  <= 1'b0;
            r_hazard_on <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_hz_prev   <= bus.hazard_btn;
            r_stay      <= w_stay_next;
            r_tw_left   <= w_tl_next;
            r_tw_right  <= w_tr_next;
            r_hazard_on <= (w_next == S_HAZARD);
        end
    end

    assign bus.stay          = r_stay;
    assign bus.twinkle_left  = r_tw_left;
    assign bus.twinkle_right = r_tw_right;
    assign bus.hazard_on     = r_hazard_on;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with a deadline-based reference model
// checked every cycle, plus literal expectations at key points.
module tb_turn_signal_ctrl;

    localparam int H = 4;

    localparam int M_OFF   = 0;
    localparam int M_IDLE  = 1;
    localparam int M_LEFT  = 2;
    localparam int M_RIGHT = 3;
    localparam int M_HAZ   = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    turn_signal_ctrl_if ifc ();

    turn_signal_ctrl #(.HOLD_CYCLES(H)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode plus the absolute edge number at which blinking ends.
    int       n_edge;
    int       mode;
    int       expire;
    logic     prev_btn;
    logic     he;
    logic [3:0] exp_out;

    initial begin
        n_edge   = 0;
        mode     = M_OFF;
        expire   = 0;
        prev_btn = 1'b0;
        exp_out  = 4'b0000;
    end

    always @(posedge clk) begin
        n_edge = n_edge + 1;
        if (!rst_n) begin
            mode     = M_OFF;
            prev_btn = 1'b0;
        end else begin
            he       = ifc.hazard_btn & ~prev_btn;
            prev_btn = ifc.hazard_btn;
            if (!ifc.power_on) begin
                mode = M_OFF;
            end else if (mode == M_OFF) begin
                mode = M_IDLE;
            end else if (mode == M_HAZ) begin
                if (he) mode = M_IDLE;
            end else if (he) begin
                mode = M_HAZ;
            end else if (ifc.turn_left_req != ifc.turn_right_req) begin
                mode   = ifc.turn_left_req ? M_LEFT : M_RIGHT;
                expire = n_edge + H;
            end else if (ifc.turn_left_req && ifc.turn_right_req) begin
                if (mode != M_IDLE) expire = n_edge + H;
            end else if (mode != M_IDLE && n_edge >= expire) begin
                mode = M_IDLE;
            end
        end
        case (mode)
            M_IDLE:  exp_out = {ifc.brake, 3'b000};
            M_LEFT:  exp_out = {ifc.brake, 3'b100};
            M_RIGHT: exp_out = {ifc.brake, 3'b010};
            M_HAZ:   exp_out = 4'b1111;
            default: exp_out = 4'b0000;
        endcase
    end

    function automatic logic [3:0] dut_out();
        return {ifc.stay, ifc.twinkle_left, ifc.twinkle_right, ifc.hazard_on};
    endfunction

    always @(negedge clk) begin
        if (n_edge > 0) begin
            total = total + 1;
            if (dut_out() !== exp_out) begin
                bad = bad + 1;
                $display("FAIL model edge=%0d got=%b want=%b (stay,tl,tr,hz)",
                         n_edge, dut_out(), exp_out);
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] want);
        total = total + 1;
        if (dut_out() !== want) begin
            bad = bad + 1;
            $display("FAIL %s got=%b want=%b (stay,tl,tr,hz)", nm, dut_out(), want);
        end
    endtask

    task automatic drv(input logic p, input logic l, input logic r,
                       input logic hz, input logic b);
        ifc.power_on       = p;
        ifc.turn_left_req  = l;
        ifc.turn_right_req = r;
        ifc.hazard_btn     = hz;
        ifc.brake          = b;
    endtask

    task automatic tick(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0);
        tick(2);
        chk("reset", 4'b0000);

        rst_n = 1'b1;
        drv(1, 0, 0, 0, 0);
        tick(1);
        chk("power_idle", 4'b0000);

        // One-shot left request
        drv(1, 1, 0, 0, 0); tick(1); chk("oneshot_k", 4'b0100);
        drv(1, 0, 0, 0, 0); tick(1); chk("oneshot_k1", 4'b0100);
        tick(1); chk("oneshot_k2", 4'b0100);
        tick(1); chk("oneshot_k3", 4'b0100);
        tick(1); chk("oneshot_k4", 4'b0000);

        // Direct swap left -> right
        drv(1, 1, 0, 0, 0); tick(10); chk("swap_left", 4'b0100);
        drv(1, 0, 1, 0, 0); tick(1);  chk("swap_right", 4'b0010);
        drv(1, 0, 0, 0, 0); tick(3);  chk("swap_hold", 4'b0010);
        tick(1); chk("swap_expire", 4'b0000);

        // Hazard held while left active
        drv(1, 1, 0, 0, 0); tick(1);  chk("hz_pre_left", 4'b0100);
        drv(1, 1, 0, 1, 0); tick(1);  chk("hz_enter", 4'b1111);
        tick(19); chk("hz_held", 4'b1111);
        drv(1, 0, 0, 0, 0); tick(1);  chk("hz_release", 4'b1111);
        drv(1, 0, 0, 1, 1); tick(1);  chk("hz_exit_brake", 4'b1000);
        drv(1, 0, 0, 0, 0); tick(1);  chk("idle_nobrake", 4'b0000);

        // Brake overlay in RIGHT
        drv(1, 0, 1, 0, 0); tick(1);  chk("brk_k", 4'b0010);
        drv(1, 0, 0, 0, 1); tick(1);  chk("brk_on", 4'b1010);
        drv(1, 0, 0, 0, 0); tick(1);  chk("brk_off", 4'b0010);
        tick(1); chk("brk_k3", 4'b0010);
        tick(1); chk("brk_k4", 4'b0000);

        // Power off coincident with hazard edge
        drv(1, 0, 0, 1, 0); tick(1);  chk("hz_on2", 4'b1111);
        drv(1, 0, 0, 0, 0); tick(1);
        drv(0, 0, 0, 1, 0); tick(1);  chk("pwroff_hzedge", 4'b0000);
        drv(1, 0, 0, 1, 0); tick(1);  chk("repower_idle", 4'b0000);
        drv(1, 0, 0, 0, 0); tick(1);

        // Hazard pressed while off is absorbed
        drv(0, 0, 0, 0, 0); tick(1);
        drv(0, 0, 0, 1, 0); tick(1);
        drv(1, 0, 0, 1, 0); tick(1);  chk("off_press_absorbed", 4'b0000);
        tick(1); chk("off_press_still_idle", 4'b0000);
        drv(1, 0, 0, 0, 0); tick(1);

        // Hazard edge beats turn; exit lands in IDLE then held turn resumes
        drv(1, 1, 0, 1, 0); tick(1);  chk("hz_beats_turn", 4'b1111);
        drv(1, 1, 0, 0, 0); tick(1);  chk("hz_keep", 4'b1111);
        drv(1, 1, 0, 1, 0); tick(1);  chk("hz_exit_idle", 4'b0000);
        tick(1); chk("held_turn_resume", 4'b0100);

        // Both requests high in IDLE stays idle
        drv(1, 0, 0, 0, 0); tick(H + 1);
        drv(1, 1, 1, 0, 0); tick(1);  chk("both_idle", 4'b0000);

        // Reset mid-blink
        drv(1, 1, 0, 0, 0); tick(1);  chk("pre_reset_left", 4'b0100);
        rst_n = 1'b0; tick(1);        chk("reset_midblink", 4'b0000);
        rst_n = 1'b1; drv(1, 0, 0, 0, 0); tick(2);

        // Mixed stimulus checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            drv(($urandom_range(0, 40) != 0),
                ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 9) == 0) ? ~ifc.hazard_btn : ifc.hazard_btn,
                ($urandom_range(0, 3) == 0));
            rst_n = ($urandom_range(0, 150) != 0);
            tick(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
